// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  localparam logic CH_ALU = 1'b0;
  localparam logic CH_MEM = 1'b1;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-way round-robin arbiter with transfer-qualified history
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       transfer
);

  logic last_grant;

  // Grants are forced off during reset so nothing is accepted that would then be lost.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == CH_ALU) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign transfer = |(valid & grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= CH_MEM;
    end else if (transfer) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load writeback
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              reg_write,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] data
);

  logic [1:0]          grant;
  logic                transfer;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_live;
  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_next;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    ({req1_valid, req0_valid}),
    .grant    (grant),
    .transfer (transfer)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_rd   = grant[1] ? req1_rd   : req0_rd;
  assign sel_data = grant[1] ? req1_data : req0_data;
  assign sel_live = transfer && (sel_rd != ADDR_W'(ZERO_REG));

  // Alloc is applied after the clear so a new producer supersedes the retiring one.
  always_comb begin
    sb_next = sb;
    if (transfer) begin
      sb_next[sel_rd] = 1'b0;
    end
    if (alloc_valid) begin
      sb_next[alloc_rd] = 1'b1;
    end
    sb_next[ZERO_REG] = 1'b0;
  end

  assign rs_busy = sb[rs];
  assign rt_busy = sb[rt];

  // Writes to $0 are consumed but leave the register-file port untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write <= 1'b0;
      Rd        <= '0;
      data      <= '0;
      sb        <= '0;
    end else begin
      reg_write <= sel_live;
      if (sel_live) begin
        Rd   <= sel_rd;
        data <= sel_data;
      end
      sb <= sb_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, alloc_valid;
  logic [4:0]  req0_rd, req1_rd, alloc_rd, rs, rt;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rs_busy, rt_busy, reg_write;
  logic [4:0]  Rd;
  logic [31:0] data;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;
  localparam logic [31:0] DD = 32'hDDDD_0004;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .rs          (rs),
    .rt          (rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .reg_write   (reg_write),
    .Rd          (Rd),
    .data        (data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0; rs = 5'd3; rt = 5'd0;
    tick(); tick();
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_rd", 32'(Rd), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_rs_busy", 32'(rs_busy), 32'd0);
    reset = 1'b0;

    // single ALU write, one-cycle latency
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h60C0_0180;
    #1;
    chk("single_r0_ready", 32'(req0_ready), 32'd1);
    chk("single_r1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("single_we", 32'(reg_write), 32'd1);
    chk("single_rd", 32'(Rd), 32'd5);
    chk("single_data", data, 32'h60C0_0180);
    tick();
    chk("single_we_off", 32'(reg_write), 32'd0);
    chk("single_rd_hold", 32'(Rd), 32'd5);

    // fresh reset, then contention alternates starting with ch0
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = DA;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = DB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_r0_ready", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_r1_ready", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("alt_we", 32'(reg_write), 32'd1);
      chk("alt_rd", 32'(Rd), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_data", data, (k % 2 == 0) ? DA : DB);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // last grant was ch1, so ch0 wins; ch1 waits one cycle
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = DC;
    req1_valid = 1'b1; req1_rd = 5'd4; req1_data = DD;
    #1;
    chk("hold_c1_r1_ready", 32'(req1_ready), 32'd0);
    chk("hold_c1_r0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("hold_c2_r1_ready", 32'(req1_ready), 32'd1);
    chk("hold_c2_rd", 32'(Rd), 32'd3);
    tick();
    req1_valid = 1'b0;
    chk("hold_c3_we", 32'(reg_write), 32'd1);
    chk("hold_c3_rd", 32'(Rd), 32'd4);
    chk("hold_c3_data", data, DD);

    // write to $0 is accepted and discarded
    req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hFFFF_FFFF;
    #1;
    chk("zero_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("zero_we", 32'(reg_write), 32'd0);

    // scoreboard set, no bypass, clear on transfer
    alloc_valid = 1'b1; alloc_rd = 5'd2; rs = 5'd2; rt = 5'd0;
    #1;
    chk("sb_no_bypass", 32'(rs_busy), 32'd0);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("sb_set", 32'(rs_busy), 32'd1);
    chk("sb_rt_zero", 32'(rt_busy), 32'd0);
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = DB;
    #1;
    chk("sb_r1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("sb_cleared", 32'(rs_busy), 32'd0);
    chk("sb_we", 32'(reg_write), 32'd1);
    chk("sb_rd", 32'(Rd), 32'd2);

    // write to an unallocated register leaves its bit clear
    rt = 5'd9;
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = DC;
    tick();
    req0_valid = 1'b0;
    chk("sb_unalloc_we", 32'(reg_write), 32'd1);
    chk("sb_unalloc_busy", 32'(rt_busy), 32'd0);

    // re-allocate, then simultaneous alloc and clear: set wins
    alloc_valid = 1'b1; alloc_rd = 5'd2;
    tick();
    chk("sb_realloc", 32'(rs_busy), 32'd1);
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = DD;
    tick();
    alloc_valid = 1'b0; req1_valid = 1'b0;
    chk("sb_set_wins", 32'(rs_busy), 32'd1);
    chk("sb_set_wins_we", 32'(reg_write), 32'd1);

    // bit 0 is never set
    alloc_valid = 1'b1; alloc_rd = 5'd0; rt = 5'd0;
    tick();
    alloc_valid = 1'b0;
    chk("sb_bit0", 32'(rt_busy), 32'd0);

    // reset mid-operation with both channels valid
    rt = 5'd2;
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = DA;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = DB;
    reset = 1'b1;
    #1;
    chk("mid_rst_r0_ready", 32'(req0_ready), 32'd0);
    chk("mid_rst_r1_ready", 32'(req1_ready), 32'd0);
    tick();
    chk("mid_rst_we", 32'(reg_write), 32'd0);
    chk("mid_rst_rs_busy", 32'(rs_busy), 32'd0);
    chk("mid_rst_rt_busy", 32'(rt_busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_r0_ready", 32'(req0_ready), 32'd1);
    chk("post_rst_r1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_rst_we", 32'(reg_write), 32'd1);
    chk("post_rst_rd", 32'(Rd), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (reg_write, Rd, data) between two writeback requesters: channel 0 (ALU result) and channel 1 (load/memory result).
- Round-robin arbitration with valid/ready handshakes; the granted write is registered and presented to the register file one cycle later.
- Holds a pending-write scoreboard so the issue stage can test whether the register file's Rs/Rt read operands are stale.

Parameters:
- DATA_W, 32, width of write data and read data.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  ALU channel has a write.
- req0_rd  input  ADDR_W  ALU destination register.
- req0_data  input  DATA_W  ALU result.
- req0_ready  output  1  ALU write accepted this cycle.
- req1_valid  input  1  load channel has a write.
- req1_rd  input  ADDR_W  load destination register.
- req1_data  input  DATA_W  load result.
- req1_ready  output  1  load write accepted this cycle.
- alloc_valid  input  1  issue stage marks a destination as pending.
- alloc_rd  input  ADDR_W  register being allocated.
- rs  input  ADDR_W  source operand 1 to check.
- rt  input  ADDR_W  source operand 2 to check.
- rs_busy  output  1  rs has a pending write.
- rt_busy  output  1  rt has a pending write.
- reg_write  output  1  write enable to the register file.
- Rd  output  ADDR_W  write address to the register file.
- data  output  DATA_W  write data to the register file.

Behaviour:
- Reset values: reg_write=0, Rd=0, data=0, scoreboard all 0, last_grant=1. With last_grant=1, channel 0 wins the first contention.
- Arbitration is combinational within the cycle:
  - Only one channel valid: that channel is granted.
  - Both valid: the channel not equal to last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = grant to channel N. A transfer occurs when reqN_valid && reqN_ready.
- Requesters must hold valid, rd and data stable until ready.
- Ready never asserts without valid.
- last_grant updates only on a transfer.
- Write output registers: on a transfer, the next cycle shows reg_write=1, Rd=rd and data=data. Latency is 1 cycle.
- With no transfer, reg_write=0 next cycle. Rd and data hold their previous values.
- Sustained throughput is one write per cycle. Back-to-back transfers produce back-to-back reg_write pulses.
- Register 0 write: the transfer is accepted (ready=1) and last_grant updates, but reg_write stays 0 the next cycle. Writes to $0 are discarded.
- Scoreboard is NUM_REGS bits wide.
  - alloc_valid sets bit alloc_rd.
  - A transfer clears bit rd at the same clock edge as the output register load.
  - Bit 0 is never set.
- Same-cycle alloc and clear of the same register: set wins, because the new producer supersedes the old one.
- rs_busy = scoreboard[rs] and rt_busy = scoreboard[rt]. Both are combinational from the registered scoreboard, with no bypass of same-cycle alloc or clear.
- A transfer to a register whose scoreboard bit is 0 is legal. The write proceeds and the bit stays 0.
- Reset asserted mid-operation: all state returns to reset values at that edge and ready is forced to 0 during reset. An in-flight request is dropped; the requester re-presents it after reset.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and NUM_REGS defaults.
  - Channel index constants CH_ALU=0 and CH_MEM=1.
  - ZERO_REG=0.
- One sub-module: rr_arb2, a 2-way round-robin arbiter (valid[1:0], transfer, last_grant state, grant[1:0]).
- Scoreboard and output registers stay inline.

Test Plan:
- Reset, then req0_valid=1, rd=5, data=32'h60C00180 -> req0_ready=1 same cycle; next cycle reg_write=1, Rd=5, data=32'h60C00180; the cycle after, reg_write=0.
- Both valid every cycle (rd=1/data=A on ch0, rd=2/data=B on ch1) after reset -> grants alternate ch0, ch1, ch0, ...; Rd sequence 1, 2, 1, 2 with reg_write continuously 1.
- req1_valid held 3 cycles while ch0 wins the first grant -> req1_ready=0 in cycle 1, req1_ready=1 in cycle 2; ch1 data appears on data in cycle 3.
- Write to rd=0 with data=32'hFFFFFFFF -> req0_ready=1; next cycle reg_write=0.
- alloc_valid with alloc_rd=2, then rs=2 -> rs_busy=1 from the next cycle. After the ch1 transfer to rd=2, rs_busy=0 the cycle after. Alloc and transfer to rd=2 in the same cycle -> rs_busy stays 1.
- Reset asserted while both channels are valid -> both ready=0; next cycle reg_write=0, scoreboard cleared (rs_busy=rt_busy=0); first grant after reset goes to ch0.
